alu_rr_sched: RTL

//  Two-port round-robin scheduler sharing one combinational ALU (32-bit, 5-bit opcode) between two requesters.

---
 rtl/alu_rr_sched.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/alu_rr_sched.sv
// Two-port round-robin scheduler that shares one combinational ALU between two requesters.
// One op in flight: IDLE accepts, EXEC drives the ALU for a cycle, RESP holds a tagged result until taken.
module alu_rr_sched #(
  parameter int unsigned         DATA_W = 32,
  parameter int unsigned         OP_W   = 5,
  parameter logic [OP_W-1:0]     MAX_OP = 5'd15,
  parameter int unsigned         CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_src1,
  input  logic [DATA_W-1:0] req0_src2,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_src1,
  input  logic [DATA_W-1:0] req1_src2,
  output logic              req1_ready,
  output logic              alu_enable,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_src1,
  output logic [DATA_W-1:0] alu_src2,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_ovf,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_ovf,
  output logic              resp_illegal,
  output logic [CNT_W-1:0]  ovf_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r;
  logic                last_grant_r;
  logic                id_r;
  logic                illegal_r;
  logic                alu_enable_r;
  logic [OP_W-1:0]     alu_op_r;
  logic [DATA_W-1:0]   alu_src1_r;
  logic [DATA_W-1:0]   alu_src2_r;
  logic                resp_valid_r;
  logic                resp_id_r;
  logic [DATA_W-1:0]   resp_data_r;
  logic                resp_ovf_r;
  logic                resp_illegal_r;
  logic [CNT_W-1:0]    ovf_count_r;

  logic                grant0_s;
  logic                grant1_s;
  logic                sel_id_s;
  logic [OP_W-1:0]     sel_op_s;
  logic [DATA_W-1:0]   sel_src1_s;
  logic [DATA_W-1:0]   sel_src2_s;
  logic                ovf_sat_s;

  // Round-robin grant: a lone requester always wins, on contention the port not granted last time wins.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (state_r == IDLE) begin
      grant0_s = req0_valid && (!req1_valid || last_grant_r);
      grant1_s = req1_valid && (!req0_valid || !last_grant_r);
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Operand mux for the granted port.
  always_comb begin
    sel_id_s   = 1'b0;
    sel_op_s   = {OP_W{1'b0}};
    sel_src1_s = {DATA_W{1'b0}};
    sel_src2_s = {DATA_W{1'b0}};
    if (grant1_s) begin
      sel_id_s   = 1'b1;
      sel_op_s   = req1_op;
      sel_src1_s = req1_src1;
      sel_src2_s = req1_src2;
    end else begin
      sel_id_s   = 1'b0;
      sel_op_s   = req0_op;
      sel_src1_s = req0_src1;
      sel_src2_s = req0_src2;
    end
  end

  assign ovf_sat_s = (ovf_count_r == {CNT_W{1'b1}});

  // Scheduler FSM; the ALU drive registers double as the operand latch and read zero outside EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= IDLE;
      last_grant_r   <= 1'b1;
      id_r           <= 1'b0;
      illegal_r      <= 1'b0;
      alu_enable_r   <= 1'b0;
      alu_op_r       <= {OP_W{1'b0}};
      alu_src1_r     <= {DATA_W{1'b0}};
      alu_src2_r     <= {DATA_W{1'b0}};
      resp_valid_r   <= 1'b0;
      resp_id_r      <= 1'b0;
      resp_data_r    <= {DATA_W{1'b0}};
      resp_ovf_r     <= 1'b0;
      resp_illegal_r <= 1'b0;
      ovf_count_r    <= {CNT_W{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (grant0_s || grant1_s) begin
            last_grant_r <= sel_id_s;
            id_r         <= sel_id_s;
            illegal_r    <= (sel_op_s > MAX_OP);
            alu_enable_r <= (sel_op_s <= MAX_OP);
            alu_op_r     <= sel_op_s;
            alu_src1_r   <= sel_src1_s;
            alu_src2_r   <= sel_src2_s;
            state_r      <= EXEC;
          end else begin
            state_r      <= IDLE;
          end
        end
        EXEC: begin
          resp_valid_r   <= 1'b1;
          resp_id_r      <= id_r;
          resp_illegal_r <= illegal_r;
          if (illegal_r) begin
            resp_data_r <= {DATA_W{1'b0}};
            resp_ovf_r  <= 1'b0;
          end else begin
            resp_data_r <= alu_result;
            resp_ovf_r  <= alu_ovf;
          end
          alu_enable_r <= 1'b0;
          alu_op_r     <= {OP_W{1'b0}};
          alu_src1_r   <= {DATA_W{1'b0}};
          alu_src2_r   <= {DATA_W{1'b0}};
          state_r      <= RESP;
        end
        RESP: begin
          if (resp_ready) begin
            if (resp_ovf_r && !ovf_sat_s) begin
              ovf_count_r <= ovf_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              ovf_count_r <= ovf_count_r;
            end
            resp_valid_r   <= 1'b0;
            resp_id_r      <= 1'b0;
            resp_data_r    <= {DATA_W{1'b0}};
            resp_ovf_r     <= 1'b0;
            resp_illegal_r <= 1'b0;
            state_r        <= IDLE;
          end else begin
            state_r        <= RESP;
          end
        end
        default: begin
          state_r      <= IDLE;
          resp_valid_r <= 1'b0;
          alu_enable_r <= 1'b0;
        end
      endcase
    end
  end

  assign req0_ready   = grant0_s;
  assign req1_ready   = grant1_s;
  assign alu_enable   = alu_enable_r;
  assign alu_op       = alu_op_r;
  assign alu_src1     = alu_src1_r;
  assign alu_src2     = alu_src2_r;
  assign resp_valid   = resp_valid_r;
  assign resp_id      = resp_id_r;
  assign resp_data    = resp_data_r;
  assign resp_ovf     = resp_ovf_r;
  assign resp_illegal = resp_illegal_r;
  assign ovf_count    = ovf_count_r;

endmodule
